control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle sequencer/decoder for the mos6502 core. Consumes the opcode held in the
//  instruction register and the Z flag, and drives every datapath control defined in
//  common_types: il_t, mw_t, mm_t, ps_t and alu_t, plus register load strobes.
//  Sits between the IR (upstream) and the PC, ALU, register file and memory mux (downstream).
// PARAMETERS
//  UNDEF_AS_NOP  1  1: undecoded opcodes execute as NOP (EA); 0: raise illegal, halt in EX0
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  reset    in   1   synchronous, active-high reset
//  rdy      in   1   1 = advance; 0 = stall (state held, no side effects)
//  opcode   in   8   opc_t, IR output; valid in EX0/EX1
//  zflag    in   1   Z flag from status register
//  il       out  1   il_t, IR load control
//  mw       out  1   mw_t, memory READ/WRITE
//  mm       out  1   mm_t, address mux PC_ADDR/A_ADDR
//  ps       out  2   ps_t, PC control HOLD/INC/REL/ABS
//  alu      out  3   alu_t, ALU function
//  a_load   out  1   load accumulator from ALU/data bus
//  x_load   out  1   load X from ALU
//  ar_load  out  1   load address register (low byte) from data bus
//  sync     out  1   1 in an INF cycle (opcode fetch), for bench/debug
//  illegal  out  1   sticky; undecoded opcode seen (UNDEF_AS_NOP=0 only)
// BEHAVIOUR
//  - State register: state_t {INF, EX0, EX1}. reset -> INF next edge; illegal -> 0.
//  - Outputs are combinational from (state, opcode, zflag, rdy, reset).
//  - reset=1 or rdy=0: il=NOLOAD, mw=READ, mm=PC_ADDR, ps=HOLD, alu=ANOP,
//    all loads 0, sync=0; state unchanged while rdy=0.
//  - Defaults otherwise: il=NOLOAD, mw=READ, mm=PC_ADDR, ps=HOLD, alu=ANOP, loads 0.
//  - INF: il=LOAD, ps=INC, sync=1; next EX0.
//  - EX0 by opcode (all -> INF unless noted):
//    A9 LDA#: a_load, alu=ANOP (pass data), ps=INC
//    69 ADC# AADD | E9 SBC# ASUB | 29 AND# AAND | 49 EOR# AEOR | 09 ORA# AORA: a_load, ps=INC
//    E8 INX: alu=AINC, x_load, ps=HOLD
//    EA NOP: ps=HOLD
//    85 STA zp: ar_load, ps=INC; next EX1
//    4C JMP abs: ar_load, ps=INC; next EX1
//    D0 BNE: zflag=0 -> ps=REL (PC stage forms PC+1+signed offset); zflag=1 -> ps=INC
//  - EX1: 85: mm=A_ADDR, mw=WRITE, ps=HOLD. 4C: ps=ABS (PC <= {data, ar}). next INF.
//  - Undecoded opcode: UNDEF_AS_NOP=1 -> identical to EA. UNDEF_AS_NOP=0 -> illegal=1,
//    state stays EX0, outputs at defaults until reset.
//  - Cycle counts: 1-byte/imm/branch 2 cycles, STA zp and JMP abs 3 cycles.
//  - mw=WRITE only ever asserted in EX1 of 85; never while reset or rdy=0.
//  - reset mid-instruction (any state): outputs safe that cycle, INF on next edge.
//  - rdy deasserted in any state: exact resumption, no repeated or lost strobes.
// STRUCTURE
//  - common_types: widen state_t to logic[1:0] {INF, EX0, EX1}; add opcode localparams
//    (OPC_LDA_IMM=8'hA9, OPC_STA_ZP=8'h85, OPC_JMP_ABS=8'h4C, OPC_BNE=8'hD0, ...)
//    and a ctrl_t packed struct bundling il/mw/mm/ps/alu/loads.
//  - Single sub-module: control_decode (pure combinational state+opcode+zflag -> ctrl_t);
//    control_unit owns the state register, rdy/reset gating and illegal flag.
// TESTING
//  - reset=1 two cycles, release: cycle0 sync=1, il=LOAD, ps=INC; all others default.
//  - opcode=A9: INF then EX0 with a_load=1, ps=INC, alu=ANOP; third cycle sync=1.
//  - opcode=69/E9/29/49/09: EX0 alu=AADD/ASUB/AAND/AEOR/AORA respectively, a_load=1.
//  - opcode=85: EX0 ar_load=1,ps=INC; EX1 mm=A_ADDR,mw=WRITE; 4C: EX1 ps=ABS; INF after.
//  - opcode=D0: zflag=0 -> EX0 ps=REL; zflag=1 -> ps=INC; E8 -> alu=AINC, x_load=1.
//  - rdy=0 for 3 cycles in EX1 of 85: mw=READ, state held; rdy=1 -> one WRITE cycle;
//    opcode=FF with UNDEF_AS_NOP=0 -> illegal=1, stuck in EX0 until reset clears it.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared datapath control types, opcodes and state encoding for the mos6502 sequencer.
// Every control field has a named enum so the decode table reads like the datapath.
package control_unit_pkg;

    typedef enum logic [1:0] {INF = 2'd0, EX0 = 2'd1, EX1 = 2'd2} state_t;

    typedef logic [7:0] opc_t;

    typedef enum logic       {NOLOAD, LOAD}           il_t;
    typedef enum logic       {READ, WRITE}            mw_t;
    typedef enum logic       {PC_ADDR, A_ADDR}        mm_t;
    typedef enum logic [1:0] {HOLD, INC, REL, ABS}    ps_t;
    typedef enum logic [2:0] {ANOP, AADD, ASUB, AAND, AORA, AEOR, AINC} alu_t;

    localparam opc_t OPC_LDA_IMM = 8'hA9;
    localparam opc_t OPC_ADC_IMM = 8'h69;
    localparam opc_t OPC_SBC_IMM = 8'hE9;
    localparam opc_t OPC_AND_IMM = 8'h29;
    localparam opc_t OPC_EOR_IMM = 8'h49;
    localparam opc_t OPC_ORA_IMM = 8'h09;
    localparam opc_t OPC_INX     = 8'hE8;
    localparam opc_t OPC_NOP     = 8'hEA;
    localparam opc_t OPC_STA_ZP  = 8'h85;
    localparam opc_t OPC_JMP_ABS = 8'h4C;
    localparam opc_t OPC_BNE     = 8'hD0;

    typedef struct packed {
        logic sync;
        il_t  il;
        mw_t  mw;
        mm_t  mm;
        ps_t  ps;
        alu_t alu;
        logic a_load;
        logic x_load;
        logic ar_load;
    } ctrl_t;

    // Safe bundle: no strobes, memory read, PC held.
    localparam ctrl_t CTRL_IDLE = '{
        sync: 1'b0, il: NOLOAD, mw: READ, mm: PC_ADDR, ps: HOLD,
        alu: ANOP, a_load: 1'b0, x_load: 1'b0, ar_load: 1'b0
    };

endpackage

// File: rtl/control_unit_decode.sv
// Pure combinational decode: (state, opcode, zflag) -> control bundle and next state.
// Stall, reset and halt gating are applied by the owner of the state register.
module control_decode
    import control_unit_pkg::*;
#(
    parameter bit UNDEF_AS_NOP = 1'b1
) (
    input  state_t state,
    input  opc_t   opcode,
    input  logic   zflag,
    output ctrl_t  ctrl,
    output state_t next_state,
    output logic   undecoded
);

    always_comb begin
        ctrl       = CTRL_IDLE;
        next_state = INF;
        undecoded  = 1'b0;
        case (state)
            INF: begin
                ctrl.sync  = 1'b1;
                ctrl.il    = LOAD;
                ctrl.ps    = INC;
                next_state = EX0;
            end
            EX0: begin
                case (opcode)
                    OPC_LDA_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; end
                    OPC_ADC_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; ctrl.alu = AADD; end
                    OPC_SBC_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; ctrl.alu = ASUB; end
                    OPC_AND_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; ctrl.alu = AAND; end
                    OPC_EOR_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; ctrl.alu = AEOR; end
                    OPC_ORA_IMM: begin ctrl.a_load = 1'b1; ctrl.ps = INC; ctrl.alu = AORA; end
                    OPC_INX:     begin ctrl.x_load = 1'b1; ctrl.alu = AINC; end
                    OPC_NOP:     ;
                    OPC_STA_ZP, OPC_JMP_ABS: begin
                        ctrl.ar_load = 1'b1;
                        ctrl.ps      = INC;
                        next_state   = EX1;
                    end
                    // Taken branch: the PC stage adds the signed offset to PC+1.
                    OPC_BNE:     ctrl.ps = zflag ? INC : REL;
                    default: begin
                        if (!UNDEF_AS_NOP) begin
                            undecoded  = 1'b1;
                            next_state = EX0;
                        end
                    end
                endcase
            end
            EX1: begin
                case (opcode)
                    OPC_STA_ZP: begin ctrl.mm = A_ADDR; ctrl.mw = WRITE; end
                    OPC_JMP_ABS: ctrl.ps = ABS;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the mos6502 core: owns the INF/EX0/EX1 state register,
// the sticky illegal flag, and reset/rdy gating of the decoded control bundle.
module control_unit
    import control_unit_pkg::*;
#(
    parameter bit UNDEF_AS_NOP = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   rdy,
    input  opc_t   opcode,
    input  logic   zflag,
    output il_t    il,
    output mw_t    mw,
    output mm_t    mm,
    output ps_t    ps,
    output alu_t   alu,
    output logic   a_load,
    output logic   x_load,
    output logic   ar_load,
    output logic   sync,
    output logic   illegal,
    output state_t state_dbg
);

    state_t state;
    state_t next_state;
    logic   illegal_q;
    logic   undecoded;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    control_decode #(.UNDEF_AS_NOP(UNDEF_AS_NOP)) u_decode (
        .state      (state),
        .opcode     (opcode),
        .zflag      (zflag),
        .ctrl       (dec_ctrl),
        .next_state (next_state),
        .undecoded  (undecoded)
    );

    // A halted core (illegal set) keeps every strobe quiet until reset.
    always_comb begin
        ctrl = dec_ctrl;
        if (reset || !rdy || illegal_q) begin
            ctrl = CTRL_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INF;
            illegal_q <= 1'b0;
        end else if (rdy && !illegal_q) begin
            state <= next_state;
            if (undecoded) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign il        = ctrl.il;
    assign mw        = ctrl.mw;
    assign mm        = ctrl.mm;
    assign ps        = ctrl.ps;
    assign alu       = ctrl.alu;
    assign a_load    = ctrl.a_load;
    assign x_load    = ctrl.x_load;
    assign ar_load   = ctrl.ar_load;
    assign sync      = ctrl.sync;
    assign illegal   = illegal_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded into its expected
// per-cycle control vectors, queued, and consumed only on cycles where rdy is high.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int W = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   reset, rdy, zflag;
    opc_t   opcode;
    il_t    il;
    mw_t    mw;
    mm_t    mm;
    ps_t    ps;
    alu_t   alu;
    logic   a_load, x_load, ar_load, sync, illegal;
    state_t state_dbg;

    logic   reset2, rdy2, zflag2;
    opc_t   opcode2;
    il_t    il2;
    mw_t    mw2;
    mm_t    mm2;
    ps_t    ps2;
    alu_t   alu2;
    logic   a_load2, x_load2, ar_load2, sync2, illegal2;
    state_t state_dbg2;

    control_unit #(.UNDEF_AS_NOP(1'b1)) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .opcode(opcode), .zflag(zflag),
        .il(il), .mw(mw), .mm(mm), .ps(ps), .alu(alu),
        .a_load(a_load), .x_load(x_load), .ar_load(ar_load),
        .sync(sync), .illegal(illegal), .state_dbg(state_dbg)
    );

    control_unit #(.UNDEF_AS_NOP(1'b0)) dut_strict (
        .clk(clk), .reset(reset2), .rdy(rdy2), .opcode(opcode2), .zflag(zflag2),
        .il(il2), .mw(mw2), .mm(mm2), .ps(ps2), .alu(alu2),
        .a_load(a_load2), .x_load(x_load2), .ar_load(ar_load2),
        .sync(sync2), .illegal(illegal2), .state_dbg(state_dbg2)
    );

    logic [W-1:0] obs_vec, obs_vec2;
    assign obs_vec  = {sync, il, mw, mm, ps, alu, a_load, x_load, ar_load};
    assign obs_vec2 = {sync2, il2, mw2, mm2, ps2, alu2, a_load2, x_load2, ar_load2};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [W-1:0] vec(input logic s, input il_t l, input mw_t w,
                                         input mm_t m, input ps_t p, input alu_t f,
                                         input logic a, input logic x, input logic ar);
        return {s, l, w, m, p, f, a, x, ar};
    endfunction

    logic [W-1:0] idle_vec, fetch_vec;
    initial begin
        idle_vec  = vec(0, NOLOAD, READ, PC_ADDR, HOLD, ANOP, 0, 0, 0);
        fetch_vec = vec(1, LOAD,   READ, PC_ADDR, INC,  ANOP, 0, 0, 0);
    end

    // Reference: an instruction is a fetch cycle followed by its execute cycles.
    task automatic push_instr(input opc_t op, input logic z);
        exp_q.push_back(fetch_vec);
        case (op)
            8'hA9: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, ANOP, 1, 0, 0));
            8'h69: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, AADD, 1, 0, 0));
            8'hE9: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, ASUB, 1, 0, 0));
            8'h29: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, AAND, 1, 0, 0));
            8'h49: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, AEOR, 1, 0, 0));
            8'h09: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, AORA, 1, 0, 0));
            8'hE8: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, HOLD, AINC, 0, 1, 0));
            8'h85: begin
                exp_q.push_back(vec(0, NOLOAD, READ,  PC_ADDR, INC,  ANOP, 0, 0, 1));
                exp_q.push_back(vec(0, NOLOAD, WRITE, A_ADDR,  HOLD, ANOP, 0, 0, 0));
            end
            8'h4C: begin
                exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, INC, ANOP, 0, 0, 1));
                exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, ABS, ANOP, 0, 0, 0));
            end
            8'hD0: exp_q.push_back(vec(0, NOLOAD, READ, PC_ADDR, z ? INC : REL, ANOP, 0, 0, 0));
            default: exp_q.push_back(idle_vec);
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after posedge; outputs are compared at negedge.
    task automatic step(input logic rdy_v, input string tag);
        logic [W-1:0] e;
        rdy = rdy_v;
        @(negedge clk);
        e = (rdy_v && exp_q.size() > 0) ? exp_q[0] : idle_vec;
        check(tag, 32'(obs_vec), 32'(e));
        if (rdy_v && exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input opc_t op, input logic z, input int stall_pct);
        opcode = op;
        zflag  = z;
        push_instr(op, z);
        while (exp_q.size() > 0)
            step(($urandom_range(0, 99) >= stall_pct) ? 1'b1 : 1'b0, $sformatf("op%02h_z%0d", op, z));
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        rdy   = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_idle", 32'(obs_vec), 32'(idle_vec));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic step2(input logic r, input logic rst, input opc_t op,
                         input logic [W-1:0] e, input logic e_ill, input string tag);
        rdy2 = r; reset2 = rst; opcode2 = op;
        @(negedge clk);
        check({tag, "_ctrl"}, 32'(obs_vec2), 32'(e));
        check({tag, "_illegal"}, 32'(illegal2), 32'(e_ill));
        @(posedge clk);
        #1;
    endtask

    opc_t legal_ops[11] = '{8'hA9, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h09,
                            8'hE8, 8'hEA, 8'h85, 8'h4C, 8'hD0};

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; rdy = 1'b1; opcode = 8'hEA; zflag = 1'b0;
        reset2 = 1'b1; rdy2 = 1'b1; opcode2 = 8'hEA; zflag2 = 1'b0;
        @(posedge clk);
        #1;

        reset_cycles(2);

        // Directed pass over every decoded opcode, branch both ways.
        foreach (legal_ops[i]) run_instr(legal_ops[i], 1'b0, 0);
        run_instr(8'hD0, 1'b1, 0);
        run_instr(8'hFF, 1'b0, 0);

        // Stall three cycles in the STA write cycle: exactly one WRITE afterwards.
        opcode = 8'h85;
        push_instr(8'h85, 1'b0);
        step(1, "sta_inf");
        step(1, "sta_ex0");
        for (int i = 0; i < 3; i++) step(0, "sta_stall");
        step(1, "sta_write");
        run_instr(8'hA9, 1'b0, 0);

        // Reset in the middle of a JMP: quiet cycle, then a clean fetch.
        opcode = 8'h4C;
        push_instr(8'h4C, 1'b0);
        step(1, "jmp_inf");
        step(1, "jmp_ex0");
        reset_cycles(1);
        run_instr(8'hE8, 1'b0, 0);

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 200; n++) begin
            opc_t op;
            if ($urandom_range(0, 3) == 0) op = opc_t'($urandom_range(0, 255));
            else op = legal_ops[$urandom_range(0, 10)];
            run_instr(op, 1'($urandom_range(0, 1)), 30);
        end

        // Strict instance: undecoded opcode halts in EX0 with illegal raised.
        step2(1, 1, 8'hFF, idle_vec, 1'b0, "strict_reset");
        step2(1, 0, 8'hFF, fetch_vec, 1'b0, "strict_inf");
        step2(0, 0, 8'hFF, idle_vec, 1'b0, "strict_ex0_stall");
        step2(1, 0, 8'hFF, idle_vec, 1'b0, "strict_ex0_bad");
        for (int i = 0; i < 3; i++) step2(1, 0, 8'hA9, idle_vec, 1'b1, "strict_halted");
        step2(1, 1, 8'hA9, idle_vec, 1'b1, "strict_reset_cycle");
        step2(1, 0, 8'hA9, fetch_vec, 1'b0, "strict_refetch");
        step2(1, 0, 8'hA9, vec(0, NOLOAD, READ, PC_ADDR, INC, ANOP, 1, 0, 0), 1'b0, "strict_lda");
        step2(1, 0, 8'hA9, fetch_vec, 1'b0, "strict_next");

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
